// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared state enumeration, bus constants and burst address helper
package gpmc_pkg;
  localparam int BE_WIDTH = 2;
  localparam int GPMC_DW = 16;
  typedef enum logic [1:0] {IDLE, ACTIVE, READ_LAT, READ_BURST} state_t;
  // next burst address: wrapping keeps the upper bits and rolls the low log2(bl) bits
  function automatic logic [31:0] next_addr(input logic [31:0] a, input int unsigned aw,
                                            input int unsigned bl, input bit wrap);
    logic [31:0] m;
    logic [31:0] inc;
    m = bl - 1;
    inc = a + 32'd1;
    return wrap ? ((a & ~m) | (inc & m)) : (inc & ((32'd1 << aw) - 32'd1));
  endfunction
endpackage

// File: rtl/gpmc_sync_ram.sv
// gpmc_sync_ram: single-port block RAM with byte-enable write and registered read
//   clk            clock
//   we, be         write strobe and per-byte enables (active high)
//   re             read strobe; rdata updates only when re is high
//   addr, wdata    word address and write data
//   rdata          registered read data
module gpmc_sync_ram
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = GPMC_DW
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/gpmc_sync_burst.sv
// gpmc_sync_burst: synchronous multiplexed GPMC slave with burst access to a block RAM and a fabric port
//   clk, rst                      clock, asynchronous active-high reset
//   gpmc_ad_in/out/oe             multiplexed AD bus sample, read data and pad enable
//   gpmc_csn/advn/oen/wein        GPMC strobes (active low)
//   gpmc_be0n/be1n                byte enables (active low)
//   gpmc_wait                     high while read data is not yet valid
//   busy                          high while a GPMC transaction owns the RAM
//   usr_req/we/addr/wdata/be      fabric request, held until usr_ack
//   usr_ack/rdata                 completion pulse and read data
module gpmc_sync_burst
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int BURST_LEN    = 8,
  parameter int WRAP_EN      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_oen,
  input  logic                  gpmc_wein,
  input  logic                  gpmc_be0n,
  input  logic                  gpmc_be1n,
  output logic                  gpmc_wait,
  output logic                  busy,
  input  logic                  usr_req,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  input  logic [BE_WIDTH-1:0]   usr_be,
  output logic                  usr_ack,
  output logic [DATA_WIDTH-1:0] usr_rdata
);
  // the RAM output register is the first pipeline stage, so only READ_LATENCY-1 more are needed
  localparam int DEPTH = READ_LATENCY > 1 ? READ_LATENCY - 1 : 1;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr, addr_inc, ram_addr;
  logic [1:0] cnt;
  logic usr_pend, usr_go, gpmc_ok, wr_go, rd_start, adv, ram_we, ram_re;
  logic [BE_WIDTH-1:0] ram_be;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_q, tap;
  logic [DATA_WIDTH-1:0] dly [DEPTH];
  always_comb begin
    gpmc_ok = !gpmc_csn && gpmc_advn;
    wr_go = state == ACTIVE && gpmc_ok && !gpmc_wein;
    rd_start = state == ACTIVE && gpmc_ok && gpmc_wein && !gpmc_oen;
    // the read pipeline only advances when a word is issued, so an oen pause freezes it intact
    adv = rd_start || (gpmc_ok && (state == READ_LAT || (state == READ_BURST && !gpmc_oen)));
    // fabric ops only run in IDLE, where the GPMC side never touches the RAM
    usr_go = state == IDLE && gpmc_csn && usr_req && !usr_pend;
    ram_we = wr_go || (usr_go && usr_we);
    ram_re = adv || (usr_go && !usr_we);
    ram_addr = state == IDLE ? usr_addr : addr;
    ram_be = state == IDLE ? usr_be : ~{gpmc_be1n, gpmc_be0n};
    ram_wdata = state == IDLE ? usr_wdata : gpmc_ad_in;
    addr_inc = ADDR_WIDTH'(next_addr(32'(addr), ADDR_WIDTH, BURST_LEN, WRAP_EN != 0));
    tap = READ_LATENCY == 1 ? ram_q : dly[DEPTH-1];
  end
  gpmc_sync_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk), .we(ram_we), .be(ram_be), .re(ram_re),
    .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_q)
  );
  always_ff @(posedge clk)
    if (adv) begin
      dly[0] <= ram_q;
      for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      gpmc_ad_out <= '0;
      gpmc_ad_oe <= 1'b0;
      gpmc_wait <= 1'b0;
      busy <= 1'b0;
      usr_pend <= 1'b0;
      usr_ack <= 1'b0;
      usr_rdata <= '0;
    end else begin
      usr_pend <= usr_go;
      usr_ack <= usr_pend;
      if (usr_pend && !usr_we) usr_rdata <= ram_q;
      if (state != IDLE && gpmc_csn) begin
        state <= IDLE;
        gpmc_ad_out <= '0;
        gpmc_ad_oe <= 1'b0;
        gpmc_wait <= 1'b0;
        busy <= 1'b0;
      end else if (!gpmc_csn && !gpmc_advn) begin
        state <= ACTIVE;
        addr <= gpmc_ad_in[ADDR_WIDTH-1:0];
        gpmc_ad_oe <= 1'b0;
        gpmc_wait <= 1'b0;
        busy <= 1'b1;
      end else case (state)
        ACTIVE:
          if (wr_go) addr <= addr_inc;
          else if (rd_start) begin
            state <= READ_LAT;
            addr <= addr_inc;
            gpmc_wait <= 1'b1;
            cnt <= 2'(READ_LATENCY - 1);
          end
        READ_LAT: begin
          addr <= addr_inc;
          if (cnt == 2'd0) begin
            state <= READ_BURST;
            gpmc_ad_oe <= 1'b1;
            gpmc_wait <= 1'b0;
            gpmc_ad_out <= tap;
          end else cnt <= cnt - 2'd1;
        end
        READ_BURST:
          if (!gpmc_oen) begin
            addr <= addr_inc;
            gpmc_ad_out <= tap;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_gpmc_sync_burst.sv
// tb_gpmc_sync_burst: random and directed checks of a linear and a wrapping instance against a word-level memory model
module tb_gpmc_sync_burst;
  localparam int LAT = 2;
  localparam int BL = 8;
  logic clk = 0, rst = 1;
  logic [15:0] ad_in = 0;
  logic csn = 1, advn = 1, oen = 1, wein = 1, be0n = 1, be1n = 1;
  logic usr_req = 0, usr_we = 0;
  logic [7:0] usr_addr = 0;
  logic [15:0] usr_wdata = 0;
  logic [1:0] usr_be = 0;
  logic [15:0] ad_out [2];
  logic [15:0] usr_rdata [2];
  logic ad_oe [2];
  logic gwait [2];
  logic busy [2];
  logic usr_ack [2];
  logic [15:0] mem [2][256];
  logic [15:0] wbuf [16];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    gpmc_sync_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(LAT), .BURST_LEN(BL), .WRAP_EN(k)) u_dut (
      .clk(clk), .rst(rst), .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out[k]), .gpmc_ad_oe(ad_oe[k]),
      .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_oen(oen), .gpmc_wein(wein),
      .gpmc_be0n(be0n), .gpmc_be1n(be1n), .gpmc_wait(gwait[k]), .busy(busy[k]),
      .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
      .usr_be(usr_be), .usr_ack(usr_ack[k]), .usr_rdata(usr_rdata[k])
    );
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] nxt(input logic [7:0] a, input int w);
    int x;
    x = a;
    return w != 0 ? 8'((x / BL) * BL + (x + 1) % BL) : 8'((x + 1) % 256);
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_bus(input string tag, input logic oe, input logic wt, input logic bz);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s oe%0d", tag, k), 16'(ad_oe[k]), 16'(oe));
      chk($sformatf("%s wait%0d", tag, k), 16'(gwait[k]), 16'(wt));
      chk($sformatf("%s busy%0d", tag, k), 16'(busy[k]), 16'(bz));
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk_bus(tag, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s adout%0d", tag, k), ad_out[k], 16'h0);
      chk($sformatf("%s ack%0d", tag, k), 16'(usr_ack[k]), 16'h0);
      chk($sformatf("%s rdata%0d", tag, k), usr_rdata[k], 16'h0);
    end
  endtask
  task automatic gpmc_write(input logic [7:0] start, input int n, input logic [1:0] be);
    logic [7:0] a [2];
    a[0] = start;
    a[1] = start;
    csn = 0; advn = 0; ad_in = 16'(start);
    cyc();
    advn = 1; {be1n, be0n} = ~be;
    for (int i = 0; i < n; i++) begin
      wein = 0; ad_in = wbuf[i];
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        mem[k][a[k]] = merge(mem[k][a[k]], wbuf[i], be);
        a[k] = nxt(a[k], k);
      end
      @(negedge clk);
    end
    chk_bus("wr_busy", 0, 0, 1);
    wein = 1; csn = 1; be0n = 1; be1n = 1;
    cyc();
    chk_bus("wr_end", 0, 0, 0);
  endtask
  task automatic gpmc_read(input logic [7:0] start, input int n);
    logic [7:0] a [2];
    a[0] = start;
    a[1] = start;
    csn = 0; advn = 0; ad_in = 16'(start);
    cyc();
    chk_bus("rd_addr", 0, 0, 1);
    advn = 1; oen = 0; ad_in = 16'($urandom);
    for (int c = 0; c < LAT; c++) begin
      cyc();
      chk_bus("rd_lat", 0, 1, 1);
    end
    for (int i = 0; i < n; i++) begin
      cyc();
      chk_bus("rd_data", 1, 0, 1);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rd_word%0d[%0d]@%h", k, i, a[k]), ad_out[k], mem[k][a[k]]);
        a[k] = nxt(a[k], k);
      end
    end
    oen = 1; csn = 1;
    cyc();
    chk_bus("rd_end", 0, 0, 0);
  endtask
  task automatic usr_access(input logic we, input logic [7:0] addr, input logic [15:0] wd, input logic [1:0] be);
    usr_req = 1; usr_we = we; usr_addr = addr; usr_wdata = wd; usr_be = be;
    @(posedge clk);
    if (we) for (int k = 0; k < 2; k++) mem[k][addr] = merge(mem[k][addr], wd, be);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("usr_ack_early%0d", k), 16'(usr_ack[k]), 16'h0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("usr_ack%0d", k), 16'(usr_ack[k]), 16'h1);
      if (!we) chk($sformatf("usr_rdata%0d@%h", k, addr), usr_rdata[k], mem[k][addr]);
    end
    usr_req = 0;
    cyc();
    for (int k = 0; k < 2; k++) chk($sformatf("usr_ack_pulse%0d", k), 16'(usr_ack[k]), 16'h0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;
    cyc();
    for (int i = 0; i < 256; i++) begin
      usr_req = 1; usr_we = 1; usr_addr = 8'(i); usr_wdata = 16'($urandom); usr_be = 2'b11;
      @(posedge clk);
      for (int k = 0; k < 2; k++) mem[k][i] = usr_wdata;
      @(negedge clk);
      cyc();
      usr_req = 0;
      cyc();
    end
    wbuf[0] = 16'hBEEF;
    gpmc_write(8'h05, 1, 2'b11);
    gpmc_read(8'h05, 1);
    chk("beef_model", mem[0][5], 16'hBEEF);
    wbuf[0] = 16'h1234;
    gpmc_write(8'h10, 1, 2'b11);
    wbuf[0] = 16'hABCD;
    gpmc_write(8'h10, 1, 2'b10);
    gpmc_read(8'h10, 1);
    chk("be_model", mem[0][8'h10], 16'hAB34);
    gpmc_read(8'hFE, 4);
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    gpmc_write(8'h0E, 4, 2'b11);
    chk("wrap_land08", mem[1][8'h08], wbuf[2]);
    chk("lin_land10", mem[0][8'h10], wbuf[2]);
    usr_access(0, 8'h08, 0, 0);
    usr_access(0, 8'h09, 0, 0);
    usr_access(0, 8'h10, 0, 0);
    usr_access(0, 8'h0E, 0, 0);
    csn = 0; advn = 0; ad_in = 16'h0005;
    usr_req = 1; usr_we = 0; usr_addr = 8'h05;
    cyc();
    advn = 1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) chk($sformatf("arb_blocked%0d", k), 16'(usr_ack[k]), 16'h0);
      cyc();
    end
    csn = 1;
    cyc();
    for (int k = 0; k < 2; k++) chk($sformatf("arb_release%0d", k), 16'(usr_ack[k]), 16'h0);
    cyc();
    for (int k = 0; k < 2; k++) chk($sformatf("arb_accept%0d", k), 16'(usr_ack[k]), 16'h0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arb_ack%0d", k), 16'(usr_ack[k]), 16'h1);
      chk($sformatf("arb_rdata%0d", k), usr_rdata[k], 16'hBEEF);
    end
    usr_req = 0;
    cyc();
    csn = 0; advn = 0; ad_in = 16'h0020;
    cyc();
    advn = 1; oen = 0;
    cyc();
    chk_bus("abort_lat", 0, 1, 1);
    csn = 1; oen = 1;
    cyc();
    chk_bus("abort", 0, 0, 0);
    cyc();
    chk_bus("abort_after", 0, 0, 0);
    csn = 0; advn = 0; ad_in = 16'h0040;
    cyc();
    advn = 1; oen = 0;
    repeat (LAT + 2) cyc();
    chk_bus("pre_reset", 1, 0, 1);
    rst = 1;
    #1;
    chk_all_zero("async_reset");
    csn = 1; oen = 1;
    @(negedge clk);
    rst = 0;
    cyc();
    gpmc_read(8'h40, 3);
    usr_access(0, 8'h40, 0, 0);
    for (int t = 0; t < 30; t++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
        gpmc_write(8'($urandom), n, 2'($urandom));
      end else if (op == 1) gpmc_read(8'($urandom), $urandom_range(1, 8));
      else usr_access(op == 2, 8'($urandom), 16'($urandom), 2'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
